uart_tx_scheduler: RTL and testbench

UART_TX_SCHEDULER -- requirements
Module: uart_tx_scheduler

---
 rtl/uart_tx_scheduler_if.sv | 10 +
 rtl/uart_tx_scheduler.sv | 123 ++++++++++++
 tb/tb_uart_tx_scheduler.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_scheduler_if.sv
// uart_tx_scheduler_if: register bus between the TX scheduler and the UART.
interface uart_tx_scheduler_if;
   logic [31:0] uart_addr;
   logic [31:0] uart_wdata;
   logic        uart_select;
   logic        uart_write;
   logic [31:0] uart_rdata;
   modport master (output uart_addr, uart_wdata, uart_select, uart_write, input uart_rdata);
   modport slave (input uart_addr, uart_wdata, uart_select, uart_write, output uart_rdata);
endinterface

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: arbitrates two byte senders onto an edge-selected UART register bus.
// Every state registers its bus/ack outputs, so each access appears one cycle after its state.
module uart_tx_scheduler #(
   parameter int POLL_LIMIT = 1024
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [1:0]                 req,
   input  logic [7:0]                 req_data0,
   input  logic [7:0]                 req_data1,
   output logic [1:0]                 ack,
   output logic [1:0]                 err,
   input  logic                       cfg_rate_we,
   input  logic [31:0]                cfg_byte_rate,
   output logic                       busy,
   uart_tx_scheduler_if.master        uart
);
   localparam int PW = $clog2(POLL_LIMIT + 1);
   localparam logic [2:0] SETUP = 3'd0, FLAGS = 3'd1, TX_DATA = 3'd2, BYTE_RATE = 3'd4;
   typedef enum logic [3:0] {IDLE, WR_RATE, WR_DATA, GAP1, WR_SEND, GAP2, RD_FLAGS, WAIT_RD, CHK, WR_CLR, DONE} state_t;
   state_t        state;
   logic [31:0]   rate_val;
   logic          rate_pending;
   logic [7:0]    tx_byte;
   logic          g;
   logic          prio;
   logic          timeout;
   logic [PW-1:0] polls;
   logic          pick;
   assign pick = (req == 2'b11) ? prio : req[1];
   assign busy = state != IDLE;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state            <= IDLE;
         rate_val         <= '0;
         rate_pending     <= 1'b0;
         tx_byte          <= '0;
         g                <= 1'b0;
         prio             <= 1'b0;
         timeout          <= 1'b0;
         polls            <= '0;
         ack              <= '0;
         err              <= '0;
         uart.uart_select <= 1'b0;
         uart.uart_write  <= 1'b0;
         uart.uart_addr   <= '0;
         uart.uart_wdata  <= '0;
      end else begin
         uart.uart_select <= 1'b0;
         uart.uart_write  <= 1'b0;
         uart.uart_addr   <= '0;
         uart.uart_wdata  <= '0;
         ack              <= '0;
         err              <= '0;
         if (cfg_rate_we) begin
            rate_val     <= cfg_byte_rate;
            rate_pending <= 1'b1;
         end
         case (state)
            IDLE:
               if (rate_pending || cfg_rate_we) state <= WR_RATE;
               else if (|req) begin
                  g       <= pick;
                  prio    <= ~pick;
                  tx_byte <= pick ? req_data1 : req_data0;
                  polls   <= '0;
                  timeout <= 1'b0;
                  state   <= WR_DATA;
               end
            WR_RATE: begin
               // a strobe landing here keeps the flag set so the newer value is written next
               uart.uart_select <= 1'b1;
               uart.uart_write  <= 1'b1;
               uart.uart_addr   <= {29'b0, BYTE_RATE};
               uart.uart_wdata  <= rate_val;
               if (!cfg_rate_we) rate_pending <= 1'b0;
               state <= IDLE;
            end
            WR_DATA: begin
               uart.uart_select <= 1'b1;
               uart.uart_write  <= 1'b1;
               uart.uart_addr   <= {29'b0, TX_DATA};
               uart.uart_wdata  <= {24'b0, tx_byte};
               state <= GAP1;
            end
            GAP1: state <= WR_SEND;
            WR_SEND: begin
               uart.uart_select <= 1'b1;
               uart.uart_write  <= 1'b1;
               uart.uart_addr   <= {29'b0, SETUP};
               uart.uart_wdata  <= 32'd1;
               state <= GAP2;
            end
            GAP2: state <= RD_FLAGS;
            RD_FLAGS: begin
               uart.uart_select <= 1'b1;
               uart.uart_addr   <= {29'b0, FLAGS};
               polls <= polls + 1'b1;
               state <= WAIT_RD;
            end
            WAIT_RD: state <= CHK;
            CHK:
               if (uart.uart_rdata[0]) state <= WR_CLR;
               else if (polls < PW'(POLL_LIMIT)) state <= RD_FLAGS;
               else begin
                  timeout <= 1'b1;
                  state   <= WR_CLR;
               end
            WR_CLR: begin
               uart.uart_select <= 1'b1;
               uart.uart_write  <= 1'b1;
               uart.uart_addr   <= {29'b0, SETUP};
               state <= DONE;
            end
            DONE: begin
               ack   <= timeout ? 2'b00 : {g, ~g};
               err   <= timeout ? {g, ~g} : 2'b00;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: directed checks of arbitration, bus sequencing, timeout and reset.
module tb_uart_tx_scheduler;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req = 2'b00;
   logic [7:0]  d0 = 8'h00;
   logic [7:0]  d1 = 8'h00;
   logic        we = 1'b0;
   logic [31:0] rate = 32'h0;
   logic [1:0]  ack, err, a, e;
   logic        busy;
   logic        flags = 1'b1;
   logic        prev_sel = 1'b0;
   int          passes = 0;
   int          checks = 0;
   int          qa[$], qd[$], qw[$];
   int          reads;
   uart_tx_scheduler_if u();
   uart_tx_scheduler #(.POLL_LIMIT(4)) dut (
      .clk(clk), .rst(rst), .req(req), .req_data0(d0), .req_data1(d1),
      .ack(ack), .err(err), .cfg_rate_we(we), .cfg_byte_rate(rate),
      .busy(busy), .uart(u.master)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask
   task automatic wait_done(output logic [1:0] ra, output logic [1:0] re);
      ra = 2'b00;
      re = 2'b00;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (ack != 2'b00 || err != 2'b00) begin
            ra = ack;
            re = err;
            return;
         end
      end
      chk("done_timeout", 1, 0);
   endtask
   task automatic clear_log();
      qa.delete();
      qd.delete();
      qw.delete();
   endtask
   // UART model: logs each select pulse and answers FLAGS reads one cycle later
   always @(negedge clk)
      if (rst) begin
         prev_sel = 1'b0;
         u.uart_rdata = 32'h0;
      end else begin
         chk("sel_gap", {31'b0, prev_sel & u.uart_select}, 0);
         chk("addr_idle", u.uart_select ? 32'h0 : u.uart_addr, 0);
         chk("ack_err_excl", {31'b0, (ack != 0 && err != 0) || ack == 2'b11 || err == 2'b11}, 0);
         if (u.uart_select) begin
            qa.push_back(u.uart_addr);
            qd.push_back(u.uart_wdata);
            qw.push_back({31'b0, u.uart_write});
            if (!u.uart_write) u.uart_rdata = {31'b0, flags};
         end
         prev_sel = u.uart_select;
      end
   initial begin
      #12;
      chk("rst_sel", {31'b0, u.uart_select}, 0);
      chk("rst_addr", u.uart_addr, 0);
      chk("rst_busy", {31'b0, busy}, 0);
      chk("rst_ack", {30'b0, ack}, 0);
      chk("rst_err", {30'b0, err}, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("idle_busy", {31'b0, busy}, 0);
      // best-case latency, single requester 0
      clear_log();
      d0 = 8'hA5;
      req = 2'b01;
      @(negedge clk);
      req = 2'b00;
      repeat (8) @(negedge clk);
      chk("lat_pre", {30'b0, ack}, 0);
      @(negedge clk);
      chk("lat_ack", {30'b0, ack}, 32'h1);
      @(negedge clk);
      chk("lat_post", {30'b0, ack}, 0);
      chk("lat_nacc", qa.size(), 4);
      chk("lat_a0", qa[0], 2);
      chk("lat_d0", qd[0], 32'hA5);
      chk("lat_w0", qw[0], 1);
      chk("lat_a1", qa[1], 0);
      chk("lat_d1", qd[1], 1);
      chk("lat_a2", qa[2], 1);
      chk("lat_w2", qw[2], 0);
      chk("lat_a3", qa[3], 0);
      chk("lat_d3", qd[3], 0);
      chk("lat_w3", qw[3], 1);
      // rate strobe together with a request: rate write comes first
      clear_log();
      rate = 32'h0000_1458;
      we = 1'b1;
      d0 = 8'h3C;
      req = 2'b01;
      @(negedge clk);
      we = 1'b0;
      for (int i = 0; i < 10 && !(u.uart_select && u.uart_addr == 32'd2); i++) @(negedge clk);
      chk("rate_grant", {31'b0, u.uart_select && u.uart_addr == 32'd2}, 1);
      req = 2'b00;
      wait_done(a, e);
      chk("rate_ack", {30'b0, a}, 32'h1);
      chk("rate_a0", qa[0], 4);
      chk("rate_d0", qd[0], 32'h1458);
      chk("rate_w0", qw[0], 1);
      chk("rate_a1", qa[1], 2);
      chk("rate_d1", qd[1], 32'h3C);
      // timeout on requester 1 with FLAGS stuck at 0
      clear_log();
      flags = 1'b0;
      d1 = 8'h77;
      req = 2'b10;
      @(negedge clk);
      req = 2'b00;
      wait_done(a, e);
      chk("to_ack", {30'b0, a}, 0);
      chk("to_err", {30'b0, e}, 32'h2);
      @(negedge clk);
      chk("to_err_post", {30'b0, err}, 0);
      reads = 0;
      foreach (qa[i]) if (qa[i] == 1 && qw[i] == 0) reads++;
      chk("to_reads", reads, 4);
      chk("to_nacc", qa.size(), 7);
      chk("to_d0", qd[0], 32'h77);
      chk("to_clr_a", qa[6], 0);
      chk("to_clr_d", qd[6], 0);
      chk("to_clr_w", qw[6], 1);
      flags = 1'b1;
      // both requesting continuously: 0, 1, 0
      clear_log();
      d0 = 8'h11;
      d1 = 8'h22;
      req = 2'b11;
      wait_done(a, e);
      chk("rr0", {30'b0, a}, 32'h1);
      wait_done(a, e);
      chk("rr1", {30'b0, a}, 32'h2);
      wait_done(a, e);
      req = 2'b00;
      chk("rr2", {30'b0, a}, 32'h1);
      chk("rr_d0", qd[0], 32'h11);
      chk("rr_d1", qd[4], 32'h22);
      chk("rr_d2", qd[8], 32'h11);
      repeat (2) @(negedge clk);
      chk("rr_idle", {31'b0, busy}, 0);
      // reset in GAP2, then the pointer must be back on requester 0
      d0 = 8'h5A;
      req = 2'b01;
      @(negedge clk);
      req = 2'b00;
      repeat (3) @(negedge clk);
      chk("gap2_sel", {31'b0, u.uart_select}, 1);
      chk("gap2_wdata", u.uart_wdata, 1);
      rst = 1'b1;
      #1;
      chk("arst_sel", {31'b0, u.uart_select}, 0);
      chk("arst_busy", {31'b0, busy}, 0);
      chk("arst_ack", {30'b0, ack}, 0);
      chk("arst_addr", u.uart_addr, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      chk("post_rst_idle", {31'b0, busy}, 0);
      clear_log();
      d0 = 8'h66;
      d1 = 8'h99;
      req = 2'b11;
      @(negedge clk);
      req = 2'b00;
      chk("restart_busy", {31'b0, busy}, 1);
      wait_done(a, e);
      chk("restart_ack", {30'b0, a}, 32'h1);
      chk("restart_a0", qa[0], 2);
      chk("restart_d0", qd[0], 32'h66);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
